maroc_sc_serializer: RTL

//  Parametrised slow-control frame serializer for MAROC-family ASICs; generalises the fixed 829-bit transmitter.

---
 rtl/maroc_sc_pkg.sv | 31 +++
 rtl/maroc_sc_serializer_if.sv | 26 ++
 rtl/maroc_sc_serializer_sc_clk_phase.sv | 40 ++++
 rtl/maroc_sc_serializer.sv | 110 +++++++++++
 4 files changed

// File: rtl/maroc_sc_pkg.sv
// Shared types and constants for the MAROC slow-control serializer.
// State encoding is fixed so state_out reads the same with or without readback.
package maroc_sc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RESET  = 3'd1,
    ST_SHIFT  = 3'd2,
    ST_VERIFY = 3'd3,
    ST_DONE   = 3'd4
  } sc_state_e;

  localparam int MAROC3_FRAME_W = 829;

  // MAROC3 frame field offsets, bit 0 shifted first
  localparam int DAC2_LSB    = 3;
  localparam int DAC2_MSB    = 12;
  localparam int DAC1_LSB    = 13;
  localparam int DAC1_MSB    = 22;
  localparam int MASK_OR_LSB = 27;
  localparam int MASK_OR_MSB = 154;
  localparam int GAIN_LSB    = 189;
  localparam int GAIN_MSB    = 764;
  localparam int CTEST_LSB   = 765;
  localparam int CTEST_MSB   = 828;

  function automatic logic is_shift_state(sc_state_e s);
    return (s == ST_SHIFT) || (s == ST_VERIFY);
  endfunction

endpackage

// File: rtl/maroc_sc_serializer_if.sv
// Register-bank / ASIC-pin side bundle of the slow-control serializer.
// The serializer takes the slave view; whoever drives start/frame takes master.
interface maroc_sc_serializer_if #(
  parameter int FRAME_W = 829
);
  logic               start_in;
  logic [FRAME_W-1:0] frame_in;
  logic               Q_SC_in;
  logic               D_SC_out;
  logic               RSTn_SC_out;
  logic               CK_SC_out;
  logic               busy_out;
  logic               done_out;
  logic               mismatch_out;
  logic [2:0]         state_out;

  modport master (
    output start_in, frame_in, Q_SC_in,
    input  D_SC_out, RSTn_SC_out, CK_SC_out, busy_out, done_out, mismatch_out, state_out
  );

  modport slave (
    input  start_in, frame_in, Q_SC_in,
    output D_SC_out, RSTn_SC_out, CK_SC_out, busy_out, done_out, mismatch_out, state_out
  );
endinterface

// File: rtl/maroc_sc_serializer_sc_clk_phase.sv
// CK_SC phase generator: CK_DIV cycles low, CK_DIV cycles high, per bit.
// Held at phase 0 / count 0 while disabled so every pass starts on a low phase.
module sc_clk_phase #(
  parameter int CK_DIV = 1
) (
  input  logic clk_in,
  input  logic reset_n_in,
  input  logic en_i,
  output logic ck_level_o,
  output logic rise_tick_o,
  output logic end_of_bit_tick_o
);
  localparam int DW = $clog2(CK_DIV + 1);

  logic [DW-1:0] div_q;
  logic          ph_q;
  logic          last_cyc;

  assign last_cyc = (div_q == DW'(CK_DIV - 1));

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      div_q <= '0;
      ph_q  <= 1'b0;
    end else if (!en_i) begin
      div_q <= '0;
      ph_q  <= 1'b0;
    end else if (last_cyc) begin
      div_q <= '0;
      ph_q  <= ~ph_q;
    end else begin
      div_q <= div_q + DW'(1);
    end
  end

  assign ck_level_o        = ph_q;
  // rise_tick marks the last low-phase cycle, i.e. the edge on which CK_SC rises
  assign rise_tick_o       = en_i & ~ph_q & last_cyc;
  assign end_of_bit_tick_o = en_i &  ph_q & last_cyc;
endmodule

// File: rtl/maroc_sc_serializer.sv
// MAROC slow-control frame serializer: RSTn_SC pulse, then D_SC/CK_SC shift-out.
// Build with SC_READBACK_EN defined to add a VERIFY pass comparing Q_SC_in.
module maroc_sc_serializer
  import maroc_sc_pkg::*;
#(
  parameter int FRAME_W    = MAROC3_FRAME_W,
  parameter int CK_DIV     = 1,
  parameter int RST_CYCLES = 4
) (
  input  logic                   clk_in,
  input  logic                   reset_n_in,
  maroc_sc_serializer_if.slave   sc
);
  localparam int BW = $clog2(FRAME_W);
  localparam int RW = $clog2(RST_CYCLES + 1);
`ifdef SC_READBACK_EN
  localparam bit READBACK = 1'b1;
`else
  localparam bit READBACK = 1'b0;
`endif

  sc_state_e          state_q;
  logic [FRAME_W-1:0] shadow_q;
  logic [BW-1:0]      bit_q;
  logic [RW-1:0]      rcnt_q;
  logic               d_q, rstn_q, done_q, mis_q;
  logic               ck_level, rise_tick, eob_tick;
  logic               last_bit;

  assign last_bit = (bit_q == BW'(FRAME_W - 1));

  sc_clk_phase #(.CK_DIV(CK_DIV)) u_phase (
    .clk_in            (clk_in),
    .reset_n_in        (reset_n_in),
    .en_i              (is_shift_state(state_q)),
    .ck_level_o        (ck_level),
    .rise_tick_o       (rise_tick),
    .end_of_bit_tick_o (eob_tick)
  );

  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state_q  <= ST_IDLE;
      shadow_q <= '0;
      bit_q    <= '0;
      rcnt_q   <= '0;
      d_q      <= 1'b0;
      rstn_q   <= 1'b1;
      done_q   <= 1'b0;
      mis_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: if (sc.start_in) begin
          shadow_q <= sc.frame_in;
          mis_q    <= 1'b0;
          rcnt_q   <= '0;
          rstn_q   <= 1'b0;
          state_q  <= ST_RESET;
        end
        ST_RESET: if (rcnt_q == RW'(RST_CYCLES - 1)) begin
          rstn_q  <= 1'b1;
          d_q     <= shadow_q[0];
          bit_q   <= '0;
          state_q <= ST_SHIFT;
        end else begin
          rcnt_q <= rcnt_q + RW'(1);
        end
        ST_SHIFT, ST_VERIFY: begin
`ifdef SC_READBACK_EN
          if (state_q == ST_VERIFY && rise_tick && (sc.Q_SC_in != shadow_q[bit_q]))
            mis_q <= 1'b1;
`endif
          // D_SC moves with the CK_SC falling edge, giving CK_DIV setup and hold
          if (eob_tick) begin
            if (!last_bit) begin
              bit_q <= bit_q + BW'(1);
              d_q   <= shadow_q[bit_q + BW'(1)];
            end else begin
              bit_q <= '0;
              if (READBACK && state_q == ST_SHIFT) begin
                d_q     <= shadow_q[0];
                state_q <= ST_VERIFY;
              end else begin
                d_q     <= 1'b0;
                done_q  <= 1'b1;
                state_q <= ST_DONE;
              end
            end
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifndef SC_READBACK_EN
  logic unused_q_sc;
  assign unused_q_sc = sc.Q_SC_in ^ rise_tick;
`endif

  assign sc.D_SC_out     = d_q;
  assign sc.RSTn_SC_out  = rstn_q;
  assign sc.CK_SC_out    = ck_level;
  assign sc.busy_out     = (state_q != ST_IDLE);
  assign sc.done_out     = done_q;
  assign sc.mismatch_out = mis_q;
  assign sc.state_out    = state_q;
endmodule
